mips_dbus_responder: RTL and testbench

//  Data-bus responder for the single-cycle MIPS core: answers the core's memwrite/memaddr/memwritedata

---
 rtl/mips_dbus_pkg.sv | 30 +++
 rtl/mips_dbus_responder_if.sv | 21 ++
 rtl/mips_dbus_responder_byte_fifo.sv | 66 ++++++
 rtl/mips_dbus_responder.sv | 83 ++++++++
 tb/tb_mips_dbus_responder.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/mips_dbus_pkg.sv
// Shared address map, STATUS bit layout and decode helpers for the MIPS data-bus responder.
// Combinational helpers only; no state or backpressure of their own.
package mips_dbus_pkg;

    localparam logic [31:0] ADDR_TXDATA = 32'hFFFF_0000;
    localparam logic [31:0] ADDR_STATUS = 32'hFFFF_0004;
    localparam logic [31:0] ADDR_CYCCNT = 32'hFFFF_0008;

    localparam int STAT_FULL    = 0;
    localparam int STAT_EMPTY   = 1;
    localparam int STAT_OVF     = 2;
    localparam int STAT_CNT_LSB = 8;

    // Same word iff the two addresses differ only in the byte-offset bits.
    function automatic logic word_hit(input logic [31:0] a, input logic [31:0] b);
        return (a ^ b) < 32'd4;
    endfunction

    function automatic logic [31:0] status_word(input logic [7:0] cnt, input logic ovf,
                                                input logic empty, input logic full);
        logic [31:0] w;
        w = '0;
        w[STAT_CNT_LSB +: 8] = cnt;
        w[STAT_OVF]          = ovf;
        w[STAT_EMPTY]        = empty;
        w[STAT_FULL]         = full;
        return w;
    endfunction

endpackage

// File: rtl/mips_dbus_responder_if.sv
// Core data-memory port plus TX byte stream, bundled for the responder.
// master = core/consumer side, slave = responder side.
interface mips_dbus_responder_if;
    logic        memwrite;
    logic [31:0] memaddr;
    logic [31:0] memwritedata;
    logic [31:0] memreaddata;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;

    modport master (
        output memwrite, memaddr, memwritedata, tx_ready,
        input  memreaddata, tx_valid, tx_data
    );

    modport slave (
        input  memwrite, memaddr, memwritedata, tx_ready,
        output memreaddata, tx_valid, tx_data
    );
endinterface

// File: rtl/mips_dbus_responder_byte_fifo.sv
// Byte FIFO with sticky overflow flag; head is registered storage, visible the cycle after a push.
// Push while full is dropped (sets ovf) unless a pop happens on the same edge.
module byte_fifo #(
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          push_i,
    input  logic [7:0]    push_dat_i,
    input  logic          pop_i,
    input  logic          ovf_clr_i,
    output logic          full_o,
    output logic          empty_o,
    output logic [CW-1:0] count_o,
    output logic [7:0]    head_o,
    output logic          ovf_o
);
    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;
    logic          push_ok, pop_ok;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];
    assign ovf_o   = ovf_q;

    assign pop_ok  = pop_i & ~empty_o;
    assign push_ok = push_i & (~full_o | pop_ok);

    always_comb begin
        rd_ptr_d = rd_ptr_q + AW'(pop_ok);
        wr_ptr_d = wr_ptr_q + AW'(push_ok);
        count_d  = count_q + CW'(push_ok) - CW'(pop_ok);
        ovf_d    = ovf_q | (push_i & ~push_ok);
        if (ovf_clr_i) ovf_d = 1'b0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage is cleared too so tx_data reads 0 straight out of reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (push_ok) begin
            mem_q[wr_ptr_q] <= push_dat_i;
        end
    end
endmodule

// File: rtl/mips_dbus_responder.sv
// Data-bus responder: word RAM + TX FIFO/STATUS MMIO (+ CYCCNT when MIPS_DBUS_CYCCNT_EN is defined).
// Reads are combinational same-cycle; writes take effect at the clock edge; TX stream is valid/ready.
module mips_dbus_responder
    import mips_dbus_pkg::*;
#(
    parameter int RAM_WORDS  = 64,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    mips_dbus_responder_if.slave  bus
);
    localparam int RAW = $clog2(RAM_WORDS);
    localparam int CW  = $clog2(FIFO_DEPTH) + 1;

    logic [31:0]    ram_q [RAM_WORDS];
    logic           ram_hit, tx_hit, st_hit;
    logic [RAW-1:0] ram_idx;
    logic           fifo_full, fifo_empty, fifo_ovf;
    logic [CW-1:0]  fifo_cnt;
    logic [7:0]     fifo_head;
    logic [31:0]    rdata;

    assign ram_hit = bus.memaddr < 32'(4 * RAM_WORDS);
    assign ram_idx = bus.memaddr[RAW+1:2];
    assign tx_hit  = word_hit(bus.memaddr, ADDR_TXDATA);
    assign st_hit  = word_hit(bus.memaddr, ADDR_STATUS);

    always_ff @(posedge clk) begin
        if (bus.memwrite && ram_hit) ram_q[ram_idx] <= bus.memwritedata;
    end

    byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_i      (clk),
        .rst_i      (reset),
        .push_i     (bus.memwrite & tx_hit),
        .push_dat_i (bus.memwritedata[7:0]),
        .pop_i      (bus.tx_ready),
        .ovf_clr_i  (bus.memwrite & st_hit),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .count_o    (fifo_cnt),
        .head_o     (fifo_head),
        .ovf_o      (fifo_ovf)
    );

    assign bus.tx_valid = ~fifo_empty;
    assign bus.tx_data  = fifo_head;

`ifdef MIPS_DBUS_CYCCNT_EN
    logic        cyc_hit;
    logic [31:0] cyc_q, cyc_d;

    assign cyc_hit = word_hit(bus.memaddr, ADDR_CYCCNT);

    always_comb begin
        cyc_d = cyc_q + 32'd1;
        if (bus.memwrite && cyc_hit) cyc_d = bus.memwritedata;
    end

    always_ff @(posedge clk) begin
        if (reset) cyc_q <= '0;
        else       cyc_q <= cyc_d;
    end
`endif

    always_comb begin
        rdata = '0;
        if (reset) begin
            rdata = '0;
        end else if (ram_hit) begin
            rdata = ram_q[ram_idx];
        end else if (st_hit) begin
            rdata = status_word(8'(fifo_cnt), fifo_ovf, fifo_empty, fifo_full);
`ifdef MIPS_DBUS_CYCCNT_EN
        end else if (cyc_hit) begin
            rdata = cyc_q;
`endif
        end
    end

    assign bus.memreaddata = rdata;
endmodule

// File: tb/tb_mips_dbus_responder.sv
// Randomized + directed bench for mips_dbus_responder against a queue-based reference model.
module tb_mips_dbus_responder;
    import mips_dbus_pkg::*;

    localparam int RAM_WORDS  = 64;
    localparam int FIFO_DEPTH = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mips_dbus_responder_if bus();

    mips_dbus_responder #(.RAM_WORDS(RAM_WORDS), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]  q_m [$];
    logic        ovf_m;
    logic [31:0] ram_m  [RAM_WORDS];
    bit          ram_ok [RAM_WORDS];
    logic [31:0] cyc_m;
    bit          live = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_rd(input logic [31:0] a, input bit rst, output bit known);
        logic [31:0] st;
        known = 1'b1;
        if (rst) return 32'h0;
        if (!live) begin
            known = 1'b0;
            return 32'h0;
        end
        if (a < 4 * RAM_WORDS) begin
            known = ram_ok[int'(a >> 2)];
            return ram_m[int'(a >> 2)];
        end
        if (a[31:2] == ADDR_STATUS[31:2]) begin
            st = 32'h0;
            st[15:8] = 8'(q_m.size());
            st[2]    = ovf_m;
            st[1]    = (q_m.size() == 0);
            st[0]    = (q_m.size() == FIFO_DEPTH);
            return st;
        end
`ifdef MIPS_DBUS_CYCCNT_EN
        if (a[31:2] == ADDR_CYCCNT[31:2]) return cyc_m;
`endif
        return 32'h0;
    endfunction

    // One clock: drive, check combinational outputs, advance model at the edge.
    task automatic step(input bit wr, input logic [31:0] a, input logic [31:0] wd,
                        input bit rdy, input bit rst);
        bit          known, pop_m, full_m;
        logic [31:0] e;
        reset            = rst;
        bus.memwrite     = wr;
        bus.memaddr      = a;
        bus.memwritedata = wd;
        bus.tx_ready     = rdy;
        #1;
        e = exp_rd(a, rst, known);
        if (known) chk("rd", bus.memreaddata, e);
        if (live) begin
            chk("txv", 32'(bus.tx_valid), 32'(q_m.size() != 0));
            if (q_m.size() != 0) chk("txd", 32'(bus.tx_data), 32'(q_m[0]));
        end
        @(posedge clk);
        if (rst) begin
            q_m.delete();
            ovf_m = 1'b0;
            cyc_m = 32'h0;
            live  = 1'b1;
        end else if (live) begin
            pop_m  = (q_m.size() != 0) && rdy;
            full_m = (q_m.size() == FIFO_DEPTH);
            if (pop_m) void'(q_m.pop_front());
            if (wr && a[31:2] == ADDR_TXDATA[31:2]) begin
                if (!full_m || pop_m) q_m.push_back(wd[7:0]);
                else ovf_m = 1'b1;
            end
            if (wr && a[31:2] == ADDR_STATUS[31:2]) ovf_m = 1'b0;
`ifdef MIPS_DBUS_CYCCNT_EN
            if (wr && a[31:2] == ADDR_CYCCNT[31:2]) cyc_m = wd;
            else cyc_m = cyc_m + 32'd1;
`endif
        end
        if (wr && !rst && a < 4 * RAM_WORDS) begin
            ram_m[int'(a >> 2)]  = wd;
            ram_ok[int'(a >> 2)] = 1'b1;
        end
        @(negedge clk);
    endtask

    task automatic probe(input logic [31:0] a);
        reset        = 1'b0;
        bus.memwrite = 1'b0;
        bus.memaddr  = a;
        bus.tx_ready = 1'b0;
        #1;
    endtask

    initial begin
        logic [31:0] a, wd;
        bit          wr, rst, rdy;
        int          cat;
        logic [7:0]  exp_b;

        cyc_m = 32'h0;
        ovf_m = 1'b0;
        @(negedge clk);
        step(0, 32'h0, 32'h0, 0, 1);
        step(0, 32'h0, 32'h0, 0, 1);
        probe(ADDR_STATUS);
        chk("rst_status", bus.memreaddata, 32'h0000_0002);
        chk("rst_txv", 32'(bus.tx_valid), 32'h0);
        chk("rst_txd", 32'(bus.tx_data), 32'h0);

        // RAM word write/read, byte offset ignored
        step(1, 32'h10, 32'h1234_5678, 0, 0);
        probe(32'h10);
        chk("t1_ram", bus.memreaddata, 32'h1234_5678);
        probe(32'h13);
        chk("t1_ram_off", bus.memreaddata, 32'h1234_5678);

        // Stream order
        for (int i = 0; i < 3; i++) step(1, ADDR_TXDATA, 32'h41 + i, 0, 0);
        probe(ADDR_STATUS);
        chk("t2_status", bus.memreaddata, 32'h0000_0300);
        for (int i = 0; i < 3; i++) begin
            probe(32'h0);
            exp_b = 8'h41 + 8'(i);
            chk("t2_txd", 32'(bus.tx_data), 32'(exp_b));
            step(0, 32'h0, 32'h0, 1, 0);
        end
        probe(32'h0);
        chk("t2_empty", 32'(bus.tx_valid), 32'h0);

        // Overflow, ovf clear, last byte lost
        for (int i = 0; i < FIFO_DEPTH + 1; i++) step(1, ADDR_TXDATA, 32'h60 + i, 0, 0);
        probe(ADDR_STATUS);
        chk("t3_status_ovf", bus.memreaddata, 32'h0000_0805);
        step(1, ADDR_STATUS, 32'h0, 0, 0);
        probe(ADDR_STATUS);
        chk("t3_status_clr", bus.memreaddata, 32'h0000_0801);
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            probe(32'h0);
            exp_b = 8'h60 + 8'(i);
            chk("t3_txd", 32'(bus.tx_data), 32'(exp_b));
            step(0, 32'h0, 32'h0, 1, 0);
        end
        probe(32'h0);
        chk("t3_empty", 32'(bus.tx_valid), 32'h0);

        // Push into full FIFO with simultaneous pop
        for (int i = 0; i < FIFO_DEPTH; i++) step(1, ADDR_TXDATA, 32'h70 + i, 0, 0);
        step(1, ADDR_TXDATA, 32'h55, 1, 0);
        probe(ADDR_STATUS);
        chk("t4_status", bus.memreaddata, 32'h0000_0801);
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            probe(32'h0);
            exp_b = (i < FIFO_DEPTH - 1) ? 8'h71 + 8'(i) : 8'h55;
            chk("t4_txd", 32'(bus.tx_data), 32'(exp_b));
            step(0, 32'h0, 32'h0, 1, 0);
        end

        // Reset mid-stream
        for (int i = 0; i < 3; i++) step(1, ADDR_TXDATA, 32'hA0 + i, 0, 0);
        step(0, 32'h0, 32'h0, 0, 1);
        probe(ADDR_STATUS);
        chk("t5_status", bus.memreaddata, 32'h0000_0002);
        chk("t5_txv", 32'(bus.tx_valid), 32'h0);
        chk("t5_txd", 32'(bus.tx_data), 32'h0);
        probe(32'h10);
        chk("t5_ram", bus.memreaddata, 32'h1234_5678);

        // Cycle counter wrap / unmapped
        step(1, ADDR_CYCCNT, 32'hFFFF_FFFE, 0, 0);
        step(0, 32'h0, 32'h0, 0, 0);
        probe(ADDR_CYCCNT);
`ifdef MIPS_DBUS_CYCCNT_EN
        chk("t6_cyc_ff", bus.memreaddata, 32'hFFFF_FFFF);
`else
        chk("t6_cyc_off", bus.memreaddata, 32'h0);
`endif
        step(0, 32'h0, 32'h0, 0, 0);
        probe(ADDR_CYCCNT);
        chk("t6_cyc_wrap", bus.memreaddata, 32'h0);
        probe(32'hFFFF_000C);
        chk("unmapped", bus.memreaddata, 32'h0);

        // Random traffic against the model
        for (int it = 0; it < 3000; it++) begin
            rst = ($urandom_range(0, 99) < 2);
            wr  = !rst && ($urandom_range(0, 1) == 1);
            rdy = ((it / 250) % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            wd  = $urandom;
            cat = $urandom_range(0, 7);
            case (cat)
                0, 1:    a = 32'($urandom_range(0, 4 * RAM_WORDS - 1));
                2, 3, 4: a = ADDR_TXDATA | 32'($urandom_range(0, 3));
                5:       a = ADDR_STATUS | 32'($urandom_range(0, 3));
                6:       a = ADDR_CYCCNT | 32'($urandom_range(0, 3));
                default: a = ($urandom_range(0, 1) == 1) ? 32'hFFFF_000C
                                                         : 32'h0000_1000 + 32'($urandom_range(0, 32'hFFFF));
            endcase
            step(wr, a, wd, rdy, rst);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
